// File: rtl/trace_change_monitor.sv
// Sampled probe-change monitor: records {timestamp, change mask, probe values}
// into a first-word-fall-through trace buffer drained by a debug host.
module trace_change_monitor #(
    parameter int NCH   = 4,
    parameter int W     = 32,
    parameter int DEPTH = 16,
    parameter int TSW   = 24,
    parameter int DIV   = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NCH*W-1:0]         probe_i,
    input  logic                     rd_en,
    input  logic                     clr_ovf,
    output logic                     rec_valid,
    output logic [TSW-1:0]           rec_ts,
    output logic [NCH-1:0]           rec_mask,
    output logic [NCH*W-1:0]         rec_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int RW = TSW + NCH + NCH*W;

    typedef logic [RW-1:0] rec_t;

    logic [TSW-1:0]   ts_q, ts_d;
    logic [DW-1:0]    div_q, div_d;
    logic [NCH*W-1:0] prev_q, prev_d;
    logic             prev_valid_q, prev_valid_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;
    rec_t             head_q, head_d;
    rec_t             mem_q [DEPTH];

    logic             strobe;
    logic [NCH-1:0]   mask;
    logic             push_req;
    logic             push;
    logic             pop;
    logic             drop;
    rec_t             new_rec;

    always_comb begin
        strobe       = (div_q == DW'(DIV - 1));
        ts_d         = ts_q + TSW'(1);
        div_d        = strobe ? '0 : div_q + DW'(1);

        mask = '0;
        for (int k = 0; k < NCH; k++) begin
            mask[k] = !prev_valid_q || (probe_i[k*W +: W] != prev_q[k*W +: W]);
        end

        // prev tracks every strobe regardless of en so enabling never diffs stale data
        prev_d       = strobe ? probe_i : prev_q;
        prev_valid_d = prev_valid_q | strobe;

        new_rec  = {ts_q, mask, probe_i};
        push_req = strobe && en && (mask != '0);
        pop      = rd_en && (count_q != '0);
        push     = push_req && ((count_q != CW'(DEPTH)) || pop);
        drop     = push_req && !push;

        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);

        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Head register: the incoming record becomes head when the buffer would
        // otherwise be empty after this edge; outputs hold when it goes empty.
        head_d = head_q;
        if (count_d != '0) begin
            head_d = (count_q == CW'(pop)) ? new_rec : mem_q[rd_ptr_d];
        end

        ovf_d = drop | (ovf_q & ~clr_ovf);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q         <= '0;
            div_q        <= '0;
            prev_q       <= '0;
            prev_valid_q <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            head_q       <= '0;
        end else begin
            ts_q         <= ts_d;
            div_q        <= div_d;
            prev_q       <= prev_d;
            prev_valid_q <= prev_valid_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            ovf_q        <= ovf_d;
            head_q       <= head_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= new_rec;
        end
    end

    assign rec_valid                    = (count_q != '0);
    assign {rec_ts, rec_mask, rec_data} = head_q;
    assign count                        = count_q;
    assign overflow                     = ovf_q;

endmodule
